// File: rtl/display_update_scheduler.sv
// Round-robin front end for the binary-to-BCD core: grants one requester, runs a
// conversion, latches validated digits and holds them for a minimum visible time.
module display_update_scheduler #(
    parameter int HOLD_CYCLES  = 100000,
    parameter int CONV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic [7:0]  uart_data,
    output logic        uart_ready,
    input  logic        count_valid,
    input  logic [7:0]  count_data,
    output logic        count_ready,
    output logic        conv_start,
    output logic [7:0]  conv_binary,
    input  logic        conv_done,
    input  logic [11:0] conv_bcd,
    output logic [3:0]  digit_hundreds,
    output logic [3:0]  digit_tens,
    output logic [3:0]  digit_ones,
    output logic        update_tick,
    output logic        source,
    output logic        busy,
    output logic        error
);

    localparam int TMAX = (HOLD_CYCLES > CONV_TIMEOUT) ? HOLD_CYCLES : CONV_TIMEOUT;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    // WAIT starts at timer 0, so the last WAIT cycle is the one whose increment would reach CONV_TIMEOUT-1.
    localparam logic [TW-1:0] WAIT_LAST = TW'(CONV_TIMEOUT - 2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_HOLD} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_timer;
    logic            r_last_grant;
    logic            r_req_src;
    logic [7:0]      r_conv_binary;
    logic [11:0]     r_digits;
    logic            r_tick;
    logic            r_source;
    logic            r_error;
    logic            w_grant;
    logic            w_xfer;

    function automatic logic bcd_ok(input logic [11:0] b);
        return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    // On a tie the requester not granted last wins; otherwise whichever is valid.
    assign w_grant = (uart_valid && count_valid) ? ~r_last_grant : count_valid;
    assign w_xfer  = uart_ready || count_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (conv_done) begin
                    w_next = S_HOLD;
                end else if (r_timer == WAIT_LAST) begin
                    w_next = S_IDLE;
                end
            end
            S_HOLD:  if (r_timer == HOLD_LAST) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        uart_ready  = 1'b0;
        count_ready = 1'b0;
        conv_start  = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy        = 1'b0;
                uart_ready  = reset && uart_valid && !w_grant;
                count_ready = reset && count_valid && w_grant;
            end
            S_START: conv_start = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer       <= '0;
            r_last_grant  <= 1'b1;
            r_req_src     <= 1'b0;
            r_conv_binary <= 8'd0;
            r_digits      <= 12'd0;
            r_tick        <= 1'b0;
            r_source      <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_conv_binary <= w_grant ? count_data : uart_data;
                        r_req_src     <= w_grant;
                        r_last_grant  <= w_grant;
                    end
                end
                S_START: r_timer <= '0;
                S_WAIT: begin
                    if (conv_done) begin
                        r_timer <= '0;
                        if (bcd_ok(conv_bcd)) begin
                            r_digits <= conv_bcd;
                            r_source <= r_req_src;
                            r_tick   <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end else if (r_timer == WAIT_LAST) begin
                        r_error <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_HOLD:  r_timer <= r_timer + TW'(1);
                default: ;
            endcase
        end
    end

    assign conv_binary    = r_conv_binary;
    assign digit_hundreds = r_digits[11:8];
    assign digit_tens     = r_digits[7:4];
    assign digit_ones     = r_digits[3:0];
    assign update_tick    = r_tick;
    assign source         = r_source;
    assign error          = r_error;

endmodule

// File: tb/tb_display_update_scheduler.sv
// Directed bench for display_update_scheduler with HOLD_CYCLES=4, CONV_TIMEOUT=8;
// the converter is modelled by driving conv_done/conv_bcd in the stimulus sequence.
module tb_display_update_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_valid;
    logic [7:0]  uart_data;
    logic        uart_ready;
    logic        count_valid;
    logic [7:0]  count_data;
    logic        count_ready;
    logic        conv_start;
    logic [7:0]  conv_binary;
    logic        conv_done;
    logic [11:0] conv_bcd;
    logic [3:0]  digit_hundreds;
    logic [3:0]  digit_tens;
    logic [3:0]  digit_ones;
    logic        update_tick;
    logic        source;
    logic        busy;
    logic        error;
    logic [11:0] w_digits;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_tick = 0;
    int n0     = 0;

    display_update_scheduler #(.HOLD_CYCLES(4), .CONV_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .uart_valid(uart_valid), .uart_data(uart_data), .uart_ready(uart_ready),
        .count_valid(count_valid), .count_data(count_data), .count_ready(count_ready),
        .conv_start(conv_start), .conv_binary(conv_binary),
        .conv_done(conv_done), .conv_bcd(conv_bcd),
        .digit_hundreds(digit_hundreds), .digit_tens(digit_tens), .digit_ones(digit_ones),
        .update_tick(update_tick), .source(source), .busy(busy), .error(error)
    );

    assign w_digits = {digit_hundreds, digit_tens, digit_ones};

    always #5 clk = ~clk;

    always @(posedge clk) if (update_tick === 1'b1) n_tick <= n_tick + 1;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; uart_valid = 1'b1; uart_data = 8'd123;
        count_valid = 1'b0; count_data = 8'd0; conv_done = 1'b0; conv_bcd = 12'd0;
        cyc(2);
        chk("rst_uart_ready", 32'(uart_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_conv_start", 32'(conv_start), 32'd0);
        chk("rst_conv_binary", 32'(conv_binary), 32'd0);
        chk("rst_digits", 32'(w_digits), 32'h000);
        chk("rst_source", 32'(source), 32'd0);
        chk("rst_tick", 32'(update_tick), 32'd0);
        chk("rst_error", 32'(error), 32'd0);

        // Single request: transfer at T, converter answers at T+6
        reset = 1'b1;
        #1;
        chk("single_uart_ready", 32'(uart_ready), 32'd1);
        chk("single_count_ready", 32'(count_ready), 32'd0);
        cyc(1);
        uart_valid = 1'b0;
        chk("single_conv_start", 32'(conv_start), 32'd1);
        chk("single_conv_binary", 32'(conv_binary), 32'd123);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_ready_drop", 32'(uart_ready), 32'd0);
        cyc(1);
        chk("single_start_pulse", 32'(conv_start), 32'd0);
        cyc(4);
        conv_done = 1'b1; conv_bcd = 12'h123;
        cyc(1);
        conv_done = 1'b0; conv_bcd = 12'h000;
        chk("single_digits", 32'(w_digits), 32'h123);
        chk("single_tick", 32'(update_tick), 32'd1);
        chk("single_source", 32'(source), 32'd0);
        cyc(1);
        chk("single_tick_end", 32'(update_tick), 32'd0);
        cyc(2);
        uart_valid = 1'b1; uart_data = 8'd9;
        #1;
        chk("single_hold_ready", 32'(uart_ready), 32'd0);
        cyc(1);
        #1;
        chk("single_rearm_ready", 32'(uart_ready), 32'd1);
        chk("single_tick_count", 32'(n_tick), 32'd1);
        uart_valid = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;

        // Contention: both valid throughout, grant must alternate
        uart_valid = 1'b1; uart_data = 8'd7; count_valid = 1'b1; count_data = 8'd200;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont%0d_uart_ready", i), 32'(uart_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d_count_ready", i), 32'(count_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            cyc(1);
            chk($sformatf("cont%0d_conv_binary", i), 32'(conv_binary), (i % 2 == 1) ? 32'd200 : 32'd7);
            cyc(1);
            conv_done = 1'b1; conv_bcd = (i % 2 == 1) ? 12'h200 : 12'h007;
            cyc(1);
            conv_done = 1'b0;
            chk($sformatf("cont%0d_digits", i), 32'(w_digits), (i % 2 == 1) ? 32'h200 : 32'h007);
            chk($sformatf("cont%0d_source", i), 32'(source), 32'(i % 2));
            chk($sformatf("cont%0d_tick", i), 32'(update_tick), 32'd1);
            cyc(4);
        end
        uart_valid = 1'b0; count_valid = 1'b0;

        // Invalid BCD: error set, digits kept, no tick, HOLD still served
        chk("inv_error_before", 32'(error), 32'd0);
        n0 = n_tick;
        uart_valid = 1'b1; uart_data = 8'd183;
        #1;
        chk("inv_uart_ready", 32'(uart_ready), 32'd1);
        cyc(1);
        uart_valid = 1'b0;
        cyc(1);
        conv_done = 1'b1; conv_bcd = 12'h1A3;
        cyc(1);
        conv_done = 1'b0; conv_bcd = 12'h000;
        chk("inv_error", 32'(error), 32'd1);
        chk("inv_digits", 32'(w_digits), 32'h200);
        chk("inv_source", 32'(source), 32'd1);
        chk("inv_tick", 32'(update_tick), 32'd0);
        chk("inv_busy", 32'(busy), 32'd1);
        count_valid = 1'b1; count_data = 8'd55;
        cyc(3);
        chk("inv_hold_busy", 32'(busy), 32'd1);
        #1;
        chk("inv_hold_ready", 32'(count_ready), 32'd0);
        cyc(1);
        chk("inv_hold_done", 32'(busy), 32'd0);
        chk("inv_tick_count", 32'(n_tick), 32'(n0));
        count_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("inv_error_reset", 32'(error), 32'd0);
        reset = 1'b1;

        // Timeout: no conv_done, IDLE and error at T+9
        n0 = n_tick;
        uart_valid = 1'b1; uart_data = 8'd55;
        #1;
        chk("to_uart_ready", 32'(uart_ready), 32'd1);
        cyc(1);
        uart_valid = 1'b0;
        cyc(7);
        chk("to_t8_busy", 32'(busy), 32'd1);
        chk("to_t8_error", 32'(error), 32'd0);
        cyc(1);
        chk("to_t9_error", 32'(error), 32'd1);
        chk("to_t9_busy", 32'(busy), 32'd0);
        chk("to_t9_digits", 32'(w_digits), 32'h000);
        count_valid = 1'b1; count_data = 8'd42;
        #1;
        chk("to_next_ready", 32'(count_ready), 32'd1);
        cyc(1);
        count_valid = 1'b0;
        chk("to_next_binary", 32'(conv_binary), 32'd42);
        cyc(2);
        conv_done = 1'b1; conv_bcd = 12'h042;
        cyc(1);
        conv_done = 1'b0; conv_bcd = 12'h000;
        chk("to_next_digits", 32'(w_digits), 32'h042);
        chk("to_next_source", 32'(source), 32'd1);
        chk("to_next_tick", 32'(update_tick), 32'd1);
        chk("to_next_error", 32'(error), 32'd1);
        chk("to_tick_count", 32'(n_tick), 32'(n0));
        cyc(4);

        // Reset during WAIT, late conv_done after release must be ignored
        uart_valid = 1'b1; uart_data = 8'd99;
        cyc(1);
        uart_valid = 1'b0;
        cyc(2);
        uart_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_conv_start", 32'(conv_start), 32'd0);
        chk("mid_conv_binary", 32'(conv_binary), 32'd0);
        chk("mid_digits", 32'(w_digits), 32'h000);
        chk("mid_source", 32'(source), 32'd0);
        chk("mid_error", 32'(error), 32'd0);
        chk("mid_tick", 32'(update_tick), 32'd0);
        chk("mid_uart_ready", 32'(uart_ready), 32'd0);
        uart_valid = 1'b0;
        n0 = n_tick;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        conv_done = 1'b1; conv_bcd = 12'h099;
        cyc(1);
        conv_done = 1'b0; conv_bcd = 12'h000;
        chk("late_digits", 32'(w_digits), 32'h000);
        chk("late_busy", 32'(busy), 32'd0);
        chk("late_tick", 32'(update_tick), 32'd0);
        cyc(1);
        chk("late_tick_count", 32'(n_tick), 32'(n0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
